// File: rtl/write_once_bank_arbiter_pkg.sv
// Shared types and constants for the write-once register bank arbiter.
package write_once_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        COMMIT,
        RESP
    } state_t;

    localparam int DATA_W = 16;
    localparam int LOCK_BIT = 0;
    localparam logic [DATA_W-1:0] WRITE_MASK = 16'hFFFE;

endpackage

// File: rtl/write_once_bank_arbiter_if.sv
// Requester-side handshake bus: packed per-requester req/addr/data and the completion response.
interface write_once_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4
);
    logic [NUM_REQ-1:0]                       req;
    logic [NUM_REQ*ADDR_W-1:0]                req_addr;
    logic [NUM_REQ*write_once_pkg::DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]                       gnt;
    logic                                     ack;
    logic                                     err;

    modport master (output req, req_addr, req_data, input gnt, ack, err);
    modport slave  (input req, req_addr, req_data, output gnt, ack, err);
endinterface

// File: rtl/write_once_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, else lowest overall.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && (IDX_W'(i) >= ptr) && !found) begin
                winner = IDX_W'(i);
                found  = 1'b1;
            end
        end
        // nothing at or above the pointer: wrap to the lowest requester
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                winner = IDX_W'(i);
                found  = 1'b1;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/write_once_bank_arbiter.sv
// Round-robin arbitrated bank of write-once registers; lock bit comes from bit 0 of the first accepted write.
// Optional WRITE_ONCE_GLOBAL_UNLOCK_EN adds unlock_all, which clears every lock while idle.
module write_once_bank_arbiter
    import write_once_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                       Clk,
    input  logic                       ip_resetn,
`ifdef WRITE_ONCE_GLOBAL_UNLOCK_EN
    input  logic                       unlock_all,
`endif
    write_once_bank_arbiter_if.slave   bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_data_out,
    output logic [NUM_REGS-1:0]        lock_status
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    arb_win;
    logic                any_req;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                reject;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] locks;
    logic [NUM_REGS-1:0] sel;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                ack_q;
    logic                err_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .winner  (arb_win),
        .any_req (any_req)
    );

    // one-hot address decode; all-zero means the address is outside the bank
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            sel[i] = (addr_q == ADDR_W'(i));
        end
    end

    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state  <= IDLE;
            ptr    <= '0;
            win    <= '0;
            addr_q <= '0;
            data_q <= '0;
            reject <= 1'b0;
            locks  <= '0;
            gnt_q  <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
`ifdef WRITE_ONCE_GLOBAL_UNLOCK_EN
                    if (unlock_all) begin
                        locks <= '0;
                    end
`endif
                    if (any_req) begin
                        win    <= arb_win;
                        addr_q <= bus.req_addr[arb_win*ADDR_W +: ADDR_W];
                        data_q <= bus.req_data[arb_win*DATA_W +: DATA_W];
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    reject <= ~|sel | |(sel & locks);
                    state  <= COMMIT;
                end
                COMMIT: begin
                    if (!reject) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (sel[i]) begin
                                regs[i]  <= data_q & WRITE_MASK;
                                locks[i] <= data_q[LOCK_BIT];
                            end
                        end
                    end
                    // response is loaded here so it is visible during RESP alongside the new data
                    gnt_q <= NUM_REQ'(1) << win;
                    ack_q <= 1'b1;
                    err_q <= reject;
                    state <= RESP;
                end
                RESP: begin
                    gnt_q <= '0;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    ptr   <= (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_data_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_data_out[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    assign lock_status = locks;
    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_write_once_bank_arbiter.sv
// Self-checking bench for write_once_bank_arbiter against a behavioural register-bank model.
module tb_write_once_bank_arbiter;

    logic Clk;
    logic ip_resetn;
`ifdef WRITE_ONCE_GLOBAL_UNLOCK_EN
    logic unlock_all;
`endif
    logic [127:0] reg_data_out;
    logic [7:0]   lock_status;

    int total;
    int bad;

    logic [15:0] mreg [8];
    logic [7:0]  mlock;
    int          mptr;

    write_once_bank_arbiter_if #(.NUM_REQ(4), .ADDR_W(4)) bus ();

    write_once_bank_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .ADDR_W(4)) dut (
        .Clk          (Clk),
        .ip_resetn    (ip_resetn),
`ifdef WRITE_ONCE_GLOBAL_UNLOCK_EN
        .unlock_all   (unlock_all),
`endif
        .bus          (bus),
        .reg_data_out (reg_data_out),
        .lock_status  (lock_status)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
        mlock = 8'h00;
        mptr  = 0;
    endfunction

    function automatic int model_pick(input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (mptr + k) % 4;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic model_write(input int a, input logic [15:0] d);
        if (a >= 8) return 1'b1;
        if (mlock[a]) return 1'b1;
        mreg[a]  = {d[15:1], 1'b0};
        mlock[a] = d[0];
        return 1'b0;
    endfunction

    function automatic logic [127:0] model_regs();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = mreg[i];
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input int a, input logic [15:0] d);
        bus.req[i]               = 1'b1;
        bus.req_addr[i*4 +: 4]   = 4'(a);
        bus.req_data[i*16 +: 16] = d;
    endtask

    task automatic wait_ack(output logic [3:0] g, output logic e, output int n);
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (bus.ack !== 1'b1 && n < 20);
        g = bus.gnt;
        e = bus.err;
    endtask

    task automatic to_idle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        ip_resetn = 1'b0;
        bus.req   = '0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        ip_resetn = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        ip_resetn    = 1'b1;
        #2 ip_resetn = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        model_reset();
        total++; if (bus.gnt !== 4'h0)        begin bad++; $display("FAIL rst_gnt: got %h want 0", bus.gnt); end
        total++; if (bus.ack !== 1'b0)        begin bad++; $display("FAIL rst_ack: got %b want 0", bus.ack); end
        total++; if (bus.err !== 1'b0)        begin bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
        total++; if (reg_data_out !== '0)     begin bad++; $display("FAIL rst_regs: got %h want 0", reg_data_out); end
        total++; if (lock_status !== 8'h00)   begin bad++; $display("FAIL rst_locks: got %h want 0", lock_status); end
        ip_resetn = 1'b1;
        @(posedge Clk); #1;
        total++; if (bus.ack !== 1'b0)        begin bad++; $display("FAIL idle_ack: got %b want 0", bus.ack); end
    endtask

    task automatic test_lock();
        int          tr [2]  = '{0, 1};
        logic [15:0] td [2]  = '{16'h1235, 16'hAAAA};
        for (int t = 0; t < 2; t++) begin
            logic [3:0] g;
            logic       e, ee;
            int         n, w;
            set_req(tr[t], 2, td[t]);
            w  = model_pick(4'(1 << tr[t]));
            ee = model_write(2, td[t]);
            mptr = (w + 1) % 4;
            wait_ack(g, e, n);
            bus.req[tr[t]] = 1'b0;
            total++; if (n !== 3)                     begin bad++; $display("FAIL lock_lat%0d: got %0d want 3", t, n); end
            total++; if (g !== 4'(1 << w))            begin bad++; $display("FAIL lock_gnt%0d: got %h want %h", t, g, 4'(1 << w)); end
            total++; if (e !== ee)                    begin bad++; $display("FAIL lock_err%0d: got %b want %b", t, e, ee); end
            total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL lock_regs%0d: got %h want %h", t, reg_data_out, model_regs()); end
            total++; if (lock_status !== mlock)       begin bad++; $display("FAIL lock_locks%0d: got %h want %h", t, lock_status, mlock); end
            to_idle();
        end
        total++; if (reg_data_out[47:32] !== 16'h1234) begin bad++; $display("FAIL lock_reg2: got %h want 1234", reg_data_out[47:32]); end
    endtask

    task automatic test_rr_order();
        int addrs [4] = '{0, 1, 6, 7};
        do_reset();
        for (int round = 0; round < 2; round++) begin
            logic [3:0] mask;
            mask = 4'hF;
            for (int i = 0; i < 4; i++) set_req(i, addrs[i], 16'(16'h0010 * (i + 1)));
            for (int k = 0; k < 4; k++) begin
                logic [3:0] g;
                logic       e, ee;
                int         n, w;
                w  = model_pick(mask);
                ee = model_write(addrs[w], 16'(16'h0010 * (w + 1)));
                mptr = (w + 1) % 4;
                wait_ack(g, e, n);
                bus.req[w] = 1'b0;
                mask[w]    = 1'b0;
                total++; if (g !== 4'(1 << k))        begin bad++; $display("FAIL rr_order r%0d k%0d: got %h want %h", round, k, g, 4'(1 << k)); end
                total++; if (n !== ((k == 0) ? 3 : 4)) begin bad++; $display("FAIL rr_spacing r%0d k%0d: got %0d want %0d", round, k, n, (k == 0) ? 3 : 4); end
                total++; if (e !== ee)                begin bad++; $display("FAIL rr_err r%0d k%0d: got %b want %b", round, k, e, ee); end
            end
            total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL rr_regs r%0d: got %h want %h", round, reg_data_out, model_regs()); end
            to_idle();
        end
    endtask

    task automatic test_bounds_and_relock();
        int          ta [3] = '{9, 3, 3};
        logic [15:0] td [3] = '{16'h1111, 16'h00F0, 16'h0F0F};
        for (int t = 0; t < 3; t++) begin
            logic [3:0] g;
            logic       e, ee;
            int         n, w;
            set_req(2, ta[t], td[t]);
            w  = model_pick(4'b0100);
            ee = model_write(ta[t], td[t]);
            mptr = (w + 1) % 4;
            wait_ack(g, e, n);
            bus.req[2] = 1'b0;
            total++; if (g !== 4'b0100)               begin bad++; $display("FAIL bnd_gnt%0d: got %h want 4", t, g); end
            total++; if (e !== ee)                    begin bad++; $display("FAIL bnd_err%0d: got %b want %b", t, e, ee); end
            total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL bnd_regs%0d: got %h want %h", t, reg_data_out, model_regs()); end
            total++; if (lock_status !== mlock)       begin bad++; $display("FAIL bnd_locks%0d: got %h want %h", t, lock_status, mlock); end
            to_idle();
        end
        total++; if (reg_data_out[63:48] !== 16'h0F0E) begin bad++; $display("FAIL bnd_reg3: got %h want 0f0e", reg_data_out[63:48]); end
    endtask

    task automatic test_reset_abort();
        logic [3:0] g;
        logic       e;
        int         n;
        set_req(2, 5, 16'h1357);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        ip_resetn = 1'b0;
        bus.req   = '0;
        #1;
        total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL abort_ack0: got %b want 0", bus.ack); end
        @(posedge Clk); #1;
        total++; if (bus.gnt !== 4'h0) begin bad++; $display("FAIL abort_gnt: got %h want 0", bus.gnt); end
        ip_resetn = 1'b1;
        model_reset();
        @(posedge Clk); #1;
        total++; if (bus.ack !== 1'b0)              begin bad++; $display("FAIL abort_ack1: got %b want 0", bus.ack); end
        total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL abort_regs: got %h want %h", reg_data_out, model_regs()); end
        total++; if (lock_status !== mlock)         begin bad++; $display("FAIL abort_locks: got %h want %h", lock_status, mlock); end
        set_req(3, 5, 16'h0008);
        void'(model_write(5, 16'h0008));
        mptr = 0;
        wait_ack(g, e, n);
        bus.req[3] = 1'b0;
        total++; if (n !== 3)        begin bad++; $display("FAIL abort_idle_lat: got %0d want 3", n); end
        total++; if (g !== 4'b1000)  begin bad++; $display("FAIL abort_idle_gnt: got %h want 8", g); end
        total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL abort_rewrite: got %h want %h", reg_data_out, model_regs()); end
        to_idle();
    endtask

    task automatic test_random();
        for (int batch = 0; batch < 30; batch++) begin
            logic [3:0]  mask;
            int          ra [4];
            logic [15:0] rd [4];
            bit          first;
            if (batch % 8 == 0) do_reset();
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                ra[i] = int'($urandom_range(0, 11));
                rd[i] = 16'($urandom);
                if (mask[i]) set_req(i, ra[i], rd[i]);
            end
            first = 1'b1;
            while (mask != 4'h0) begin
                logic [3:0] g;
                logic       e, ee;
                int         n, w;
                w  = model_pick(mask);
                ee = model_write(ra[w], rd[w]);
                mptr = (w + 1) % 4;
                wait_ack(g, e, n);
                bus.req[w] = 1'b0;
                mask[w]    = 1'b0;
                total++; if (n !== (first ? 3 : 4))       begin bad++; $display("FAIL rnd_lat b%0d: got %0d want %0d", batch, n, first ? 3 : 4); end
                total++; if (g !== 4'(1 << w))            begin bad++; $display("FAIL rnd_gnt b%0d: got %h want %h", batch, g, 4'(1 << w)); end
                total++; if (e !== ee)                    begin bad++; $display("FAIL rnd_err b%0d: got %b want %b", batch, e, ee); end
                total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL rnd_regs b%0d: got %h want %h", batch, reg_data_out, model_regs()); end
                total++; if (lock_status !== mlock)       begin bad++; $display("FAIL rnd_locks b%0d: got %h want %h", batch, lock_status, mlock); end
                first = 1'b0;
            end
            to_idle();
        end
    endtask

`ifdef WRITE_ONCE_GLOBAL_UNLOCK_EN
    task automatic test_unlock();
        logic [15:0] td [2] = '{16'h5555, 16'h5554};
        do_reset();
        for (int t = 0; t < 2; t++) begin
            logic [3:0] g;
            logic       e, ee;
            int         n, w;
            set_req(1, 4, td[t]);
            w  = model_pick(4'b0010);
            ee = model_write(4, td[t]);
            mptr = (w + 1) % 4;
            wait_ack(g, e, n);
            bus.req[1] = 1'b0;
            total++; if (e !== ee)                    begin bad++; $display("FAIL unl_err%0d: got %b want %b", t, e, ee); end
            total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL unl_regs%0d: got %h want %h", t, reg_data_out, model_regs()); end
            total++; if (lock_status !== mlock)       begin bad++; $display("FAIL unl_locks%0d: got %h want %h", t, lock_status, mlock); end
            to_idle();
            if (t == 0) begin
                unlock_all = 1'b1;
                @(posedge Clk); #1;
                unlock_all = 1'b0;
                mlock = 8'h00;
                total++; if (lock_status !== 8'h00)         begin bad++; $display("FAIL unl_clear: got %h want 0", lock_status); end
                total++; if (reg_data_out !== model_regs()) begin bad++; $display("FAIL unl_retain: got %h want %h", reg_data_out, model_regs()); end
            end
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
`ifdef WRITE_ONCE_GLOBAL_UNLOCK_EN
        unlock_all = 1'b0;
`endif
        test_reset();
        test_lock();
        test_rr_order();
        test_bounds_and_relock();
        test_reset_abort();
        test_random();
`ifdef WRITE_ONCE_GLOBAL_UNLOCK_EN
        test_unlock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
